add_pattern_engine: RTL and testbench
=====================================

Name: add_pattern_engine

Overview:
- Synthesizable stimulus/check engine for the 4-bit operand adder.
- Operand, operand and golden tables are loaded through a write port. On `start` it waits a warm-up interval, then streams one operand pair per cycle into the adder and checks each sum against the golden table.
- Keeps an error count and reports pass/fail.
- Used for on-chip self-test of the CIM accumulate datapath.

Parameters:
- DATA_W, 4, operand width; sum width is DATA_W+1.
- DEPTH, 100, number of patterns per run (1..2^ADDR_W).
- ADDR_W, 7, table address width.
- WARMUP, 10, idle cycles between start acceptance and first issue (0 allowed).
- LATENCY, 0, cycles from operand issue to valid adder result (0 = combinational adder fed by registered operands).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- load_en  in  1  table write strobe
- load_addr  in  ADDR_W  table write index
- load_a  in  DATA_W  operand A entry
- load_b  in  DATA_W  operand B entry
- load_c  in  DATA_W+1  golden sum entry
- start  in  1  begin run (sampled in IDLE or DONE)
- op_a  out  DATA_W  operand A to adder
- op_b  out  DATA_W  operand B to adder
- op_valid  out  1  op_a/op_b carry a live pattern
- res_c  in  DATA_W+1  adder sum
- busy  out  1  high in WARMUP/RUN/DRAIN
- done  out  1  level, high in DONE
- pass  out  1  done && err_cnt==0
- err_cnt  out  ADDR_W+1  mismatches this run
- fail_valid  out  1  one-cycle pulse on each mismatch
- fail_idx  out  ADDR_W  pattern index of that mismatch

Behaviour:
- Reset (async, any state): state=IDLE.
  - op_a=op_b=0, op_valid=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, fail_idx=0.
  - Tables are not cleared.
- Table write: when load_en=1 and state is IDLE or DONE, write A/B/C[load_addr] at the clock edge.
  - Ignored while busy.
  - load_addr>=DEPTH is ignored.
- FSM states: IDLE, WARMUP, RUN, DRAIN, DONE.
- IDLE/DONE -> WARMUP on start=1.
  - Clears err_cnt, done and the warm-up counter.
  - If load_en and start occur in the same cycle, the write completes before the run begins.
- WARMUP: count WARMUP cycles, then go to RUN (WARMUP=0 goes straight to RUN the next cycle).
  - op_valid=0.
- RUN: issue index i=0..DEPTH-1, one per cycle, no stalls.
  - op_a/op_b/op_valid are registered outputs from A[i]/B[i].
  - After issuing i=DEPTH-1 -> DRAIN.
- Compare pipeline: a valid/index delay line of depth LATENCY.
  - Check cycle for index i is the cycle op_valid for i is high plus LATENCY.
  - In that cycle, res_c is compared bitwise against C[i].
  - Mismatch, including any X/Z bit in simulation (case-inequality): err_cnt+1, and the next cycle has fail_valid=1, fail_idx=i.
- DRAIN: op_valid=0, op_a=op_b=0; wait until the delay line is empty (LATENCY cycles; 0 cycles if LATENCY=0), then -> DONE.
- DONE: done=1, pass=(err_cnt==0), busy=0. Held until the next start or reset.
- start while busy: ignored.
- err_cnt cannot overflow because its width is ADDR_W+1 and DEPTH<=2^ADDR_W.
- Reset mid-RUN: immediate return to IDLE; partial results discarded.
- Total run length from the start edge to done=1: WARMUP + DEPTH + LATENCY + 2 cycles.

Test Plan:
- Load DEPTH=100 random A,B with C=A+B, WARMUP=10, LATENCY=0, pulse start -> op_valid high exactly 100 consecutive cycles starting 11 cycles after the start edge; done=1, pass=1, err_cnt=0, no fail_valid pulses.
- Same tables, golden C[7] corrupted (A=15, B=15, C=5'd29 instead of 30) -> exactly one fail_valid with fail_idx=7; err_cnt=1, pass=0, done=1.
- Adder model forced to drop the carry (returns 4-bit sum) and all patterns have A+B>=16 -> err_cnt equals the count of carry patterns; fail_idx sequence strictly increasing.
- LATENCY=2 with a 2-stage registered adder model, correct golden -> pass=1; the same table at LATENCY=0 against that model fails.
- Assert rst at RUN index 40 -> all outputs return to reset values asynchronously; tables intact; a new start yields pass=1 with a full 100-pattern run.
- start and load_en pulsed during RUN -> both ignored: run completes unchanged, table entry unmodified, err_cnt=0.

Source files
------------

// File: rtl/add_pattern_engine.sv
// add_pattern_engine: on-chip self-test engine that streams stored operand pairs into an adder
// and checks each returned sum against a golden table, counting and reporting mismatches.
module add_pattern_engine #(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 100,
  parameter int ADDR_W  = 7,
  parameter int WARMUP  = 10,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_a,
  input  logic [DATA_W-1:0] load_b,
  input  logic [DATA_W:0]   load_c,
  input  logic              start,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic [DATA_W:0]   res_c,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_idx
);
  localparam int CW = $clog2((WARMUP > LATENCY ? WARMUP : LATENCY) + 1) + 1;
  localparam logic [CW-1:0] WU = CW'(WARMUP);
  localparam logic [CW-1:0] LT = CW'(LATENCY);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_mem_a [2**ADDR_W];
  logic [DATA_W-1:0] r_mem_b [2**ADDR_W];
  logic [DATA_W:0]   r_mem_c [2**ADDR_W];
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_idx, r_fail_idx, w_iidx, w_chk_idx;
  logic [DATA_W-1:0] r_op_a, r_op_b;
  logic [ADDR_W:0]   r_err;
  logic              r_op_valid, r_fail_valid;
  logic              w_idle, w_start, w_issue, w_chk_v, w_mis;
  assign w_idle  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start = w_idle && start;
  assign w_issue = (w_next == S_RUN);
  assign w_iidx  = (r_state == S_RUN) ? r_idx + ADDR_W'(1) : '0;
  assign w_mis   = w_chk_v && (res_c !== r_mem_c[w_chk_idx]);
  // Tables are writable only while idle; a write coinciding with start lands before the first read.
  always_ff @(posedge clk) begin
    if (load_en && w_idle && ({1'b0, load_addr} < DEPTH_L)) begin
      r_mem_a[load_addr] <= load_a;
      r_mem_b[load_addr] <= load_b;
      r_mem_c[load_addr] <= load_c;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = start ? S_WARMUP : r_state;
      S_WARMUP:       w_next = (r_cnt == WU) ? S_RUN : S_WARMUP;
      S_RUN:          w_next = (r_idx == LAST) ? S_DRAIN : S_RUN;
      S_DRAIN:        w_next = (r_cnt == LT) ? S_DONE : S_DRAIN;
      default:        w_next = S_IDLE;
    endcase
  end
  // r_cnt restarts on every state change, so it times both the warm-up and the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_valid   <= 1'b0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      r_idx        <= w_issue ? w_iidx : r_idx;
      r_op_valid   <= w_issue;
      r_op_a       <= w_issue ? r_mem_a[w_iidx] : '0;
      r_op_b       <= w_issue ? r_mem_b[w_iidx] : '0;
      r_err        <= w_start ? '0 : r_err + {{ADDR_W{1'b0}}, w_mis};
      r_fail_valid <= w_mis;
      r_fail_idx   <= w_mis ? w_chk_idx : r_fail_idx;
    end
  end
  generate
    if (LATENCY == 0) begin : g_comb
      assign w_chk_v   = r_op_valid;
      assign w_chk_idx = r_idx;
    end else begin : g_pipe
      logic              r_dv [LATENCY];
      logic [ADDR_W-1:0] r_di [LATENCY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < LATENCY; k++) begin
            r_dv[k] <= 1'b0;
            r_di[k] <= '0;
          end
        end else begin
          r_dv[0] <= r_op_valid;
          r_di[0] <= r_idx;
          for (int k = 1; k < LATENCY; k++) begin
            r_dv[k] <= r_dv[k-1];
            r_di[k] <= r_di[k-1];
          end
        end
      end
      assign w_chk_v   = r_dv[LATENCY-1];
      assign w_chk_idx = r_di[LATENCY-1];
    end
  endgenerate
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign op_valid   = r_op_valid;
  assign busy       = (r_state == S_WARMUP) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign pass       = done && (r_err == '0);
  assign err_cnt    = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_idx   = r_fail_idx;
endmodule

// File: tb/tb_add_pattern_engine.sv
// tb_add_pattern_engine: randomized self-check of add_pattern_engine against a cycle-level
// behavioural model derived from run timing (start edge + offsets) and table contents.
module tb_add_pattern_engine;
  localparam int W = 10, D = 100, L = 0;
  localparam int D2 = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic load_en = 1'b0, start = 1'b0, start2 = 1'b0;
  logic [6:0] load_addr = '0;
  logic [3:0] load_a = '0, load_b = '0;
  logic [4:0] load_c = '0;
  logic [3:0] op_a, op_b, op2_a, op2_b, fail2_idx;
  logic op_valid, op2_valid, busy, busy2, done, done2, pass, pass2, fail_valid, fail2_valid;
  logic [4:0] res_c, res2_c, p1, p2, q1, q2, err2_cnt;
  logic [7:0] err_cnt;
  logic [6:0] fail_idx;
  int n_tests = 0, n_fail = 0, mode = 0;
  int cyc = 0, s = 0, np = 0, lastf = -1, np2 = 0;
  bit ran = 0, bz;
  logic [3:0] ma [D];
  logic [3:0] mb [D];
  logic [4:0] mc [D];
  bit mis [D];

  always #5 clk = ~clk;

  add_pattern_engine u0 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_a(load_a),
    .load_b(load_b), .load_c(load_c), .start(start), .op_a(op_a), .op_b(op_b),
    .op_valid(op_valid), .res_c(res_c), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_idx(fail_idx)
  );

  add_pattern_engine #(.DATA_W(4), .DEPTH(D2), .ADDR_W(4), .WARMUP(0), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr[3:0]), .load_a(load_a),
    .load_b(load_b), .load_c(load_c), .start(start2), .op_a(op2_a), .op_b(op2_b),
    .op_valid(op2_valid), .res_c(res2_c), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2_cnt), .fail_valid(fail2_valid), .fail_idx(fail2_idx)
  );

  // Adder models: mode 0 exact, mode 1 drops the carry, mode 2 is a 2-stage registered adder.
  always @(posedge clk) begin
    p1 <= {1'b0, op_a} + {1'b0, op_b};
    p2 <= p1;
    q1 <= {1'b0, op2_a} + {1'b0, op2_b};
    q2 <= q1;
  end
  assign res_c  = (mode == 0) ? {1'b0, op_a} + {1'b0, op_b} : (mode == 1) ? {1'b0, 4'(op_a + op_b)} : p2;
  assign res2_c = q2;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Sum the adder presents during the check cycle of pattern i.
  function automatic logic [4:0] exp_res(int i);
    if (mode == 0) return {1'b0, ma[i]} + {1'b0, mb[i]};
    if (mode == 1) return {1'b0, 4'(ma[i] + mb[i])};
    if (i >= 2) return {1'b0, ma[i-2]} + {1'b0, mb[i-2]};
    return 5'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) ran = 0;
    else begin
      bz = ran && (cyc - s) <= W + D + L + 1;
      cyc++;
      if (load_en && !bz && load_addr < D) begin
        ma[load_addr] = load_a;
        mb[load_addr] = load_b;
        mc[load_addr] = load_c;
      end
      if (start && !bz) begin
        ran = 1;
        s = cyc;
        for (int i = 0; i < D; i++) mis[i] = exp_res(i) != mc[i];
      end
    end
  end

  always @(negedge clk) begin
    int k, b, ecnt;
    bit eov, efv, edone;
    if (!rst) begin
      if (!ran) begin
        chk("idle_busy", busy, 0); chk("idle_done", done, 0); chk("idle_pass", pass, 0);
        chk("idle_opv", op_valid, 0); chk("idle_err", err_cnt, 0); chk("idle_fv", fail_valid, 0);
      end else begin
        k = cyc - s;
        b = k - W - 2;
        eov = k >= W + 1 && k <= W + D;
        edone = k > W + D + L + 1;
        ecnt = 0;
        for (int i = 0; i < D && i <= b; i++) ecnt += int'(mis[i]);
        efv = 0;
        if (b >= 0 && b < D) efv = mis[b];
        chk("busy", busy, !edone); chk("done", done, edone); chk("op_valid", op_valid, eov);
        chk("op_a", op_a, eov ? ma[k-W-1] : 4'd0); chk("op_b", op_b, eov ? mb[k-W-1] : 4'd0);
        chk("err_cnt", err_cnt, ecnt); chk("pass", pass, edone && ecnt == 0);
        chk("fail_valid", fail_valid, efv);
        if (efv) chk("fail_idx", fail_idx, b);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && fail_valid) begin
      if (np > 0) chk("fidx_incr", fail_idx > lastf, 1);
      np++;
      lastf = fail_idx;
    end
    if (!rst && fail2_valid) np2++;
  end

  task automatic load(int a, logic [3:0] x, logic [3:0] y, logic [4:0] z);
    load_en = 1; load_addr = 7'(a); load_a = x; load_b = y; load_c = z;
    @(negedge clk);
    load_en = 0;
  endtask

  task automatic load_rand(bit carry, int n);
    logic [3:0] x, y;
    for (int a = 0; a < n; a++) begin
      x = carry ? 4'($urandom_range(15, 1)) : 4'($urandom_range(15, 0));
      y = carry ? 4'($urandom_range(15, 16 - int'(x))) : 4'($urandom_range(15, 0));
      load(a, x, y, {1'b0, x} + {1'b0, y});
    end
  endtask

  task automatic wait_done(output int len);
    len = 0;
    while (!done && len < 400) begin @(negedge clk); len++; end
    if (!done) chk("done_timeout", done, 1);
  endtask

  task automatic run(output int len);
    np = 0; lastf = -1;
    start = 1; @(negedge clk); start = 0;
    wait_done(len);
  endtask

  task automatic run2(output int len);
    np2 = 0; len = 0;
    start2 = 1; @(negedge clk); start2 = 0;
    while (!done2 && len < 100) begin @(negedge clk); len++; end
    if (!done2) chk("done2_timeout", done2, 1);
  endtask

  initial begin
    int len;
    logic [3:0] a5, b5;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0); chk("rst_opv", op_valid, 0); chk("rst_fv", fail_valid, 0);
    chk("rst_fidx", fail_idx, 0);
    rst = 0;
    load_rand(0, D); mode = 0; run(len);
    chk("t1_len", len, 112); chk("t1_pass", pass, 1); chk("t1_err", err_cnt, 0); chk("t1_pulses", np, 0);
    load(7, 4'd15, 4'd15, 5'd29); run(len);
    chk("t2_err", err_cnt, 1); chk("t2_pass", pass, 0); chk("t2_done", done, 1);
    chk("t2_pulses", np, 1); chk("t2_fidx", fail_idx, 7);
    load_rand(1, D); mode = 1; run(len);
    chk("t3_err", err_cnt, 100); chk("t3_pulses", np, 100); chk("t3_pass", pass, 0);
    load_rand(0, D); mode = 2; run(len);
    chk("t4_pass_l0", pass, 0);
    mode = 0;
    load_rand(0, D2); run2(len);
    chk("l2_len", len, 20); chk("l2_pass", pass2, 1); chk("l2_err", err2_cnt, 0); chk("l2_pulses", np2, 0);
    load(3, 4'd9, 4'd9, 5'd17); run2(len);
    chk("l2b_err", err2_cnt, 1); chk("l2b_fidx", fail2_idx, 3); chk("l2b_pass", pass2, 0);
    load(3, 4'd9, 4'd9, 5'd18);
    start = 1; @(negedge clk); start = 0;
    repeat (W + 1 + 40) @(negedge clk);
    chk("r_opv_pre", op_valid, 1);
    #2 rst = 1;
    #1;
    chk("ar_busy", busy, 0); chk("ar_opv", op_valid, 0); chk("ar_opa", op_a, 0); chk("ar_opb", op_b, 0);
    chk("ar_done", done, 0); chk("ar_pass", pass, 0); chk("ar_err", err_cnt, 0);
    chk("ar_fv", fail_valid, 0); chk("ar_fidx", fail_idx, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    run(len);
    chk("t5_len", len, 112); chk("t5_pass", pass, 1); chk("t5_err", err_cnt, 0);
    np = 0; lastf = -1;
    start = 1; @(negedge clk); start = 0;
    repeat (30) @(negedge clk);
    a5 = ~ma[5]; b5 = ~mb[5];
    start = 1;
    load(5, a5, b5, 5'd0);
    start = 0;
    wait_done(len);
    chk("t6_pass", pass, 1); chk("t6_err", err_cnt, 0); chk("t6_len", len, 112 - 31);
    run(len);
    chk("t6b_pass", pass, 1); chk("t6b_len", len, 112);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
